// File: rtl/guess_entry_if.sv
// ============================================================================
// Module      : guess_entry_if
// Description : Guess bus between the player-side code editor and the history
//               block. The scorer's solved flag returns to the producer here.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface guess_entry_if;
    logic [2:0] guess0;
    logic [2:0] guess1;
    logic [2:0] guess2;
    logic [2:0] guess3;
    logic [1:0] cursor;
    logic       commit;
    logic [3:0] turn_count;
    logic       game_over;
    logic       solved;

    modport master (
        output guess0, guess1, guess2, guess3,
        output cursor, commit, turn_count, game_over,
        input  solved
    );

    modport slave (
        input  guess0, guess1, guess2, guess3,
        input  cursor, commit, turn_count, game_over,
        output solved
    );
endinterface

`default_nettype wire

// File: rtl/guess_entry.sv
// ============================================================================
// Module      : guess_entry
// Description : Edits a 4-peg code with cursor/colour buttons, commits it as a
//               one-cycle pulse, counts turns and locks after the limit/solve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_entry #(
    parameter int NUM_COLORS = 6,
    parameter int MAX_TURNS  = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   mode_i,
    input  wire logic   btn_up_i,
    input  wire logic   btn_down_i,
    input  wire logic   btn_left_i,
    input  wire logic   btn_right_i,
    input  wire logic   btn_select_i,
    guess_entry_if.master gif
);

    localparam logic [2:0] C_MAX_COLOR = 3'(NUM_COLORS - 1);
    localparam logic [3:0] C_MAX_TURNS = 4'(MAX_TURNS);

    typedef enum logic [1:0] {
        S_EDIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][2:0] guess_q, guess_d;
    logic [1:0]      cursor_q, cursor_d;
    logic [3:0]      turn_q, turn_d;
    logic [4:0]      btn_q;

    logic [4:0] w_btn;
    logic [4:0] w_press;
    logic       w_sel, w_up, w_dn, w_left, w_right;
    logic [2:0] w_peg, w_peg_up, w_peg_dn;

    // Bit order {select, up, down, left, right}
    assign w_btn   = {btn_select_i, btn_up_i, btn_down_i, btn_left_i, btn_right_i};
    assign w_press = w_btn & ~btn_q;
    assign w_sel   = w_press[4];
    assign w_up    = w_press[3];
    assign w_dn    = w_press[2];
    assign w_left  = w_press[1];
    assign w_right = w_press[0];

    assign w_peg    = guess_q[cursor_q];
    assign w_peg_up = (w_peg == C_MAX_COLOR) ? 3'd0 : w_peg + 3'd1;
    assign w_peg_dn = (w_peg == 3'd0) ? C_MAX_COLOR : w_peg - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EDIT;
            guess_q  <= '0;
            cursor_q <= 2'd0;
            turn_q   <= 4'd0;
            // Held-high history: a button held through reset release is not a press
            btn_q    <= '1;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            cursor_q <= cursor_d;
            turn_q   <= turn_d;
            btn_q    <= w_btn;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        case (state_q)
            S_EDIT: begin
                if (gif.solved) begin
                    state_d = S_DONE;
                end else if (!mode_i) begin
                    if (w_sel) begin
                        state_d = S_COMMIT;
                        if (turn_q < C_MAX_TURNS) begin
                            turn_d = turn_q + 4'd1;
                        end
                    end else if (w_up || w_dn) begin
                        // Up and down together cancel; left/right still lose priority
                        if (w_up && !w_dn) begin
                            guess_d[cursor_q] = w_peg_up;
                        end else if (w_dn && !w_up) begin
                            guess_d[cursor_q] = w_peg_dn;
                        end
                    end else if (w_right && !w_left) begin
                        cursor_d = cursor_q + 2'd1;
                    end else if (w_left && !w_right) begin
                        cursor_d = cursor_q - 2'd1;
                    end
                end
            end
            S_COMMIT: begin
                if ((turn_q == C_MAX_TURNS) || gif.solved) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_EDIT;
                    cursor_d = 2'd0;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_EDIT;
            end
        endcase
    end

    assign gif.guess0     = guess_q[0];
    assign gif.guess1     = guess_q[1];
    assign gif.guess2     = guess_q[2];
    assign gif.guess3     = guess_q[3];
    assign gif.cursor     = cursor_q;
    assign gif.commit     = (state_q == S_COMMIT);
    assign gif.turn_count = turn_q;
    assign gif.game_over  = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_guess_entry.sv
// ============================================================================
// Module      : tb_guess_entry
// Description : Self-checking bench for guess_entry (vector table + hand sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guess_entry;

    localparam logic [4:0] C_SEL = 5'b10000;
    localparam logic [4:0] C_UP  = 5'b01000;
    localparam logic [4:0] C_DN  = 5'b00100;
    localparam logic [4:0] C_L   = 5'b00010;
    localparam logic [4:0] C_R   = 5'b00001;
    localparam logic [4:0] C_NO  = 5'b00000;

    typedef struct packed {
        logic        mode;
        logic [4:0]  btn;
        logic        solved;
        logic [19:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [4:0] btn;

    always #5 clk = ~clk;

    guess_entry_if gif ();

    guess_entry #(
        .NUM_COLORS (6),
        .MAX_TURNS  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode),
        .btn_up_i     (btn[3]),
        .btn_down_i   (btn[2]),
        .btn_left_i   (btn[1]),
        .btn_right_i  (btn[0]),
        .btn_select_i (btn[4]),
        .gif          (gif)
    );

    logic [19:0] sb_q[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;

    // {g0,g1,g2,g3,cursor,commit,turn,game_over}
    function automatic logic [19:0] pk(input int g0, input int g1, input int g2, input int g3,
                                       input int cur, input int com, input int turn, input int go);
        return {3'(g0), 3'(g1), 3'(g2), 3'(g3), 2'(cur), 1'(com), 4'(turn), 1'(go)};
    endfunction

    task automatic check_out(input string name);
        logic [19:0] e;
        logic [19:0] a;
        e = sb_q.pop_front();
        a = {gif.guess0, gif.guess1, gif.guess2, gif.guess3, gif.cursor,
             gif.commit, gif.turn_count, gif.game_over};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got g=%0d-%0d-%0d-%0d cur=%0d com=%0d turn=%0d go=%0d, want g=%0d-%0d-%0d-%0d cur=%0d com=%0d turn=%0d go=%0d",
                     name, a[19:17], a[16:14], a[13:11], a[10:8], a[7:6], a[5], a[4:1], a[0],
                     e[19:17], e[16:14], e[13:11], e[10:8], e[7:6], e[5], e[4:1], e[0]);
        end
    endtask

    task automatic expect_now(input logic [19:0] e, input string name);
        sb_q.push_back(e);
        check_out(name);
    endtask

    task automatic step(input logic m, input logic [4:0] b, input logic s,
                        input logic [19:0] e, input string name);
        mode       = m;
        btn        = b;
        gif.solved = s;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic m, input logic [4:0] b, input logic [19:0] e);
        vecs.push_back('{mode: m, btn: b, solved: 1'b0, exp: e});
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        btn        = C_UP;
        gif.solved = 1'b0;

        // Editing, wrap-around, priority, commit and mode-freeze vectors
        add(0, C_UP,        pk(0,0,0,0, 0,0,0,0));
        add(0, C_NO,        pk(0,0,0,0, 0,0,0,0));
        add(0, C_UP,        pk(1,0,0,0, 0,0,0,0));
        add(0, C_NO,        pk(1,0,0,0, 0,0,0,0));
        add(0, C_UP,        pk(2,0,0,0, 0,0,0,0));
        add(0, C_NO,        pk(2,0,0,0, 0,0,0,0));
        add(0, C_R,         pk(2,0,0,0, 1,0,0,0));
        add(0, C_NO,        pk(2,0,0,0, 1,0,0,0));
        add(0, C_DN,        pk(2,5,0,0, 1,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 1,0,0,0));
        add(0, C_UP,        pk(2,0,0,0, 1,0,0,0));
        add(0, C_NO,        pk(2,0,0,0, 1,0,0,0));
        add(0, C_DN,        pk(2,5,0,0, 1,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 1,0,0,0));
        add(0, C_L,         pk(2,5,0,0, 0,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 0,0,0,0));
        add(0, C_L,         pk(2,5,0,0, 3,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 3,0,0,0));
        add(0, C_R,         pk(2,5,0,0, 0,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 0,0,0,0));
        add(0, C_UP | C_R,  pk(3,5,0,0, 0,0,0,0));
        add(0, C_NO,        pk(3,5,0,0, 0,0,0,0));
        add(0, C_UP | C_DN, pk(3,5,0,0, 0,0,0,0));
        add(0, C_NO,        pk(3,5,0,0, 0,0,0,0));
        add(0, C_DN,        pk(2,5,0,0, 0,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 0,0,0,0));
        add(0, C_R,         pk(2,5,0,0, 1,0,0,0));
        add(0, C_NO,        pk(2,5,0,0, 1,0,0,0));
        add(0, C_SEL | C_UP, pk(2,5,0,0, 1,1,1,0));
        add(0, C_UP | C_R,  pk(2,5,0,0, 0,0,1,0));
        add(0, C_NO,        pk(2,5,0,0, 0,0,1,0));
        add(1, C_UP,        pk(2,5,0,0, 0,0,1,0));
        add(1, C_NO,        pk(2,5,0,0, 0,0,1,0));
        add(1, C_R,         pk(2,5,0,0, 0,0,1,0));
        add(1, C_NO,        pk(2,5,0,0, 0,0,1,0));
        add(1, C_SEL,       pk(2,5,0,0, 0,0,1,0));
        add(1, C_UP,        pk(2,5,0,0, 0,0,1,0));
        add(0, C_UP,        pk(2,5,0,0, 0,0,1,0));
        add(0, C_NO,        pk(2,5,0,0, 0,0,1,0));
        add(0, C_UP,        pk(3,5,0,0, 0,0,1,0));
        add(0, C_NO,        pk(3,5,0,0, 0,0,1,0));

        repeat (3) @(posedge clk);
        #1;
        expect_now(pk(0,0,0,0, 0,0,0,0), "reset_state");
        release_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].mode, vecs[i].btn, vecs[i].solved, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Use up the remaining turns; the eighth commit locks the game
        for (int k = 2; k <= 8; k++) begin
            step(0, C_SEL, 0, pk(3,5,0,0, 0,1,k,0), $sformatf("commit%0d", k));
            step(0, C_NO,  0, pk(3,5,0,0, 0,0,k,(k == 8) ? 1 : 0), $sformatf("after_commit%0d", k));
        end
        step(0, C_SEL, 0, pk(3,5,0,0, 0,0,8,1), "select_in_done");
        step(0, C_NO,  0, pk(3,5,0,0, 0,0,8,1), "done_idle");
        step(0, C_UP,  0, pk(3,5,0,0, 0,0,8,1), "up_in_done");
        step(0, C_NO,  0, pk(3,5,0,0, 0,0,8,1), "done_frozen");

        // Asynchronous reset out of DONE
        btn   = C_NO;
        rst_n = 1'b0;
        #1;
        expect_now(pk(0,0,0,0, 0,0,0,0), "async_reset_done");
        release_reset();

        for (int k = 1; k <= 3; k++) begin
            step(0, C_SEL, 0, pk(0,0,0,0, 0,1,k,0), $sformatf("s_commit%0d", k));
            step(0, C_NO,  0, pk(0,0,0,0, 0,0,k,0), $sformatf("s_after%0d", k));
        end
        step(0, C_NO, 1, pk(0,0,0,0, 0,0,3,1), "solved_in_edit");
        step(0, C_NO, 0, pk(0,0,0,0, 0,0,3,1), "solved_locked");
        step(0, C_SEL, 0, pk(0,0,0,0, 0,0,3,1), "solved_no_commit");

        // Reset landing in the middle of a commit cycle
        btn   = C_NO;
        rst_n = 1'b0;
        #1;
        release_reset();
        step(0, C_SEL, 0, pk(0,0,0,0, 0,1,1,0), "pre_mid_reset");
        #2;
        rst_n = 1'b0;
        #1;
        expect_now(pk(0,0,0,0, 0,0,0,0), "reset_mid_commit");
        btn = C_NO;
        release_reset();
        step(0, C_NO, 0, pk(0,0,0,0, 0,0,0,0), "after_mid_reset");

        // Solved seen in the commit cycle ends the game immediately
        step(0, C_SEL, 0, pk(0,0,0,0, 0,1,1,0), "commit_then_solved");
        step(0, C_NO,  1, pk(0,0,0,0, 0,0,1,1), "solved_in_commit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
